// File: rtl/ysyx_22040750_mcsr_unit_if.sv
// Commit-side bus between the WB stage and the M-mode CSR unit.
interface ysyx_22040750_mcsr_unit_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned PC_W = 32
);
  logic            I_commit;
  logic [1:0]      I_csr_op;
  logic [11:0]     I_csr_addr;
  logic [XLEN-1:0] I_csr_wdata;
  logic [XLEN-1:0] O_csr_rdata;
  logic            O_csr_illegal;
  logic            I_exc;
  logic [XLEN-1:0] I_exc_cause;
  logic [PC_W-1:0] I_trap_pc;
  logic            I_irq_ack;
  logic            I_mret;
  logic            I_mtip;
  logic            I_msip_ext;
  logic            I_meip;
  logic            O_irq_req;
  logic [PC_W-1:0] O_trap_vec;
  logic [PC_W-1:0] O_mepc;

  modport master (
    output I_commit, I_csr_op, I_csr_addr, I_csr_wdata, I_exc, I_exc_cause, I_trap_pc,
           I_irq_ack, I_mret, I_mtip, I_msip_ext, I_meip,
    input  O_csr_rdata, O_csr_illegal, O_irq_req, O_trap_vec, O_mepc
  );

  modport slave (
    input  I_commit, I_csr_op, I_csr_addr, I_csr_wdata, I_exc, I_exc_cause, I_trap_pc,
           I_irq_ack, I_mret, I_mtip, I_msip_ext, I_meip,
    output O_csr_rdata, O_csr_illegal, O_irq_req, O_trap_vec, O_mepc
  );
endinterface

// File: rtl/ysyx_22040750_mcsr_unit.sv
// M-mode CSR file written at WB: atomic CSR ops, trap/mret bookkeeping,
// interrupt arbitration and mcycle/minstret counters.
module ysyx_22040750_mcsr_unit #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned VECTORED = 1,
  parameter int unsigned HAS_CNT  = 1
) (
  input logic                      I_sys_clk,
  input logic                      I_rst_n,
  ysyx_22040750_mcsr_unit_if.slave bus
);
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [XLEN-1:0] MIE_MASK   = XLEN'(12'h888);
  localparam logic [XLEN-1:0] MEPC_MASK  = ~XLEN'(3);
  localparam logic [XLEN-1:0] MTVEC_MASK = (VECTORED != 0) ? ~XLEN'(2) : ~XLEN'(3);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic            msip_q, msip_d;
  logic            mtip_q, mtip_d;
  logic            meip_q, meip_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;
  logic            irq_req_q, irq_req_d;

  logic [XLEN-1:0] mip_val, pend, rd_val, wr_val;
  logic [3:0]      irq_cause;
  logic            irq_pend, implemented, wr_en;
  logic            csr_illegal_c;
  logic [PC_W-1:0] trap_vec_c;

  // Read mux, op decode and interrupt selection
  always_comb begin
    mip_val     = '0;
    mip_val[11] = meip_q;
    mip_val[7]  = mtip_q;
    mip_val[3]  = msip_q | bus.I_msip_ext;
    pend        = mip_val & mie_q;
    irq_pend    = |pend;
    irq_cause   = pend[11] ? 4'd11 : pend[3] ? 4'd3 : pend[7] ? 4'd7 : 4'd0;

    rd_val      = '0;
    implemented = 1'b1;
    case (bus.I_csr_addr)
      A_MSTATUS: begin
        rd_val[12:11] = 2'b11;
        rd_val[7]     = mstatus_mpie_q;
        rd_val[3]     = mstatus_mie_q;
      end
      A_MIE:      rd_val = mie_q;
      A_MTVEC:    rd_val = mtvec_q;
      A_MSCRATCH: rd_val = mscratch_q;
      A_MEPC:     rd_val = mepc_q;
      A_MCAUSE:   rd_val = mcause_q;
      A_MIP:      rd_val = mip_val;
      A_MCYCLE:   if (HAS_CNT != 0) rd_val = mcycle_q; else implemented = 1'b0;
      A_MINSTRET: if (HAS_CNT != 0) rd_val = minstret_q; else implemented = 1'b0;
      default:    implemented = 1'b0;
    endcase

    csr_illegal_c = (bus.I_csr_op != 2'b00) && !implemented;

    case (bus.I_csr_op)
      OP_RS:   wr_val = rd_val | bus.I_csr_wdata;
      OP_RC:   wr_val = rd_val & ~bus.I_csr_wdata;
      default: wr_val = bus.I_csr_wdata;
    endcase
    // set/clear with a zero operand is a pure read
    wr_en = bus.I_commit && (bus.I_csr_op != 2'b00) && implemented &&
            !(bus.I_csr_op[1] && (bus.I_csr_wdata == '0));

    trap_vec_c = PC_W'(mtvec_q & ~XLEN'(3));
    if (mtvec_q[0] && irq_pend && !bus.I_exc)
      trap_vec_c = trap_vec_c + PC_W'({irq_cause, 2'b00});
  end

  // Next state: exception > irq_ack > mret > CSR write
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    msip_d         = msip_q;
    mtip_d         = bus.I_mtip;
    meip_d         = bus.I_meip;
    mcycle_d       = mcycle_q + XLEN'(1);
    minstret_d     = minstret_q + XLEN'(bus.I_commit);
    irq_req_d      = mstatus_mie_q & irq_pend & ~bus.I_exc & ~bus.I_irq_ack;

    if (bus.I_exc) begin
      mepc_d         = XLEN'(bus.I_trap_pc) & MEPC_MASK;
      mcause_d       = bus.I_exc_cause;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (bus.I_irq_ack) begin
      mepc_d         = XLEN'(bus.I_trap_pc) & MEPC_MASK;
      mcause_d       = {1'b1, (XLEN-1)'(irq_cause)};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (bus.I_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (bus.I_csr_addr)
        A_MSTATUS: begin
          mstatus_mie_d  = wr_val[3];
          mstatus_mpie_d = wr_val[7];
        end
        A_MIE:      mie_d      = wr_val & MIE_MASK;
        A_MTVEC:    mtvec_d    = wr_val & MTVEC_MASK;
        A_MSCRATCH: mscratch_d = wr_val;
        A_MEPC:     mepc_d     = wr_val & MEPC_MASK;
        A_MCAUSE:   mcause_d   = wr_val;
        A_MIP:      msip_d     = wr_val[3];
        A_MCYCLE:   mcycle_d   = wr_val;
        A_MINSTRET: minstret_d = wr_val;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      msip_q         <= 1'b0;
      mtip_q         <= 1'b0;
      meip_q         <= 1'b0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
      irq_req_q      <= 1'b0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      msip_q         <= msip_d;
      mtip_q         <= mtip_d;
      meip_q         <= meip_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
      irq_req_q      <= irq_req_d;
    end
  end

  assign bus.O_csr_rdata   = csr_illegal_c ? '0 : rd_val;
  assign bus.O_csr_illegal = csr_illegal_c;
  assign bus.O_irq_req     = irq_req_q;
  assign bus.O_trap_vec    = trap_vec_c;
  assign bus.O_mepc        = mepc_q[PC_W-1:0];
endmodule

// File: tb/tb_ysyx_22040750_mcsr_unit.sv
// Directed-vector bench for the M-mode CSR unit (XLEN=64, PC_W=32).
module tb_ysyx_22040750_mcsr_unit;
  localparam int unsigned XLEN = 64;
  localparam int unsigned PC_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ysyx_22040750_mcsr_unit_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

  ysyx_22040750_mcsr_unit #(.XLEN(XLEN), .PC_W(PC_W), .VECTORED(1), .HAS_CNT(1)) dut (
    .I_sys_clk (clk),
    .I_rst_n   (rst_n),
    .bus       (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] exp, input string tag);
    bus.I_csr_addr = a;
    #1;
    check_eq(tag, bus.O_csr_rdata, exp);
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd);
    bus.I_commit    = 1'b1;
    bus.I_csr_op    = op;
    bus.I_csr_addr  = a;
    bus.I_csr_wdata = wd;
    tick();
    bus.I_commit    = 1'b0;
    bus.I_csr_op    = 2'b00;
    bus.I_csr_wdata = '0;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.I_commit    = 1'b0;
    bus.I_csr_op    = 2'b00;
    bus.I_csr_addr  = 12'h000;
    bus.I_csr_wdata = '0;
    bus.I_exc       = 1'b0;
    bus.I_exc_cause = '0;
    bus.I_trap_pc   = '0;
    bus.I_irq_ack   = 1'b0;
    bus.I_mret      = 1'b0;
    bus.I_mtip      = 1'b0;
    bus.I_msip_ext  = 1'b0;
    bus.I_meip      = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // reset state and counter start
    rd(12'h300, 64'h1800, "rst_mstatus");
    rd(12'h305, 64'h0, "rst_mtvec");
    rd(12'hB00, 64'h0, "rst_mcycle");
    check_eq("rst_irq_req", 64'(bus.O_irq_req), 64'h0);
    repeat (3) tick();
    rd(12'hB00, 64'h3, "mcycle_after_3");

    // timer interrupt request and acknowledge
    csr(2'b10, 12'h304, 64'h80);
    csr(2'b10, 12'h300, 64'h8);
    rd(12'h300, 64'h1808, "mstatus_mie_set");
    bus.I_mtip = 1'b1;
    tick();
    check_eq("irq_req_lat1", 64'(bus.O_irq_req), 64'h0);
    tick();
    check_eq("irq_req_lat2", 64'(bus.O_irq_req), 64'h1);
    bus.I_trap_pc = 32'h1000_0103;
    bus.I_irq_ack = 1'b1;
    tick();
    bus.I_irq_ack = 1'b0;
    bus.I_mtip    = 1'b0;
    check_eq("irq_req_after_ack", 64'(bus.O_irq_req), 64'h0);
    rd(12'h342, 64'h8000_0000_0000_0007, "mcause_mtip");
    rd(12'h300, 64'h1880, "mstatus_after_ack");
    check_eq("mepc_ack", 64'(bus.O_mepc), 64'h1000_0100);
    tick();
    check_eq("irq_req_stays_low", 64'(bus.O_irq_req), 64'h0);

    // vectored mtvec
    csr(2'b01, 12'h305, 64'h8000_0001);
    rd(12'h305, 64'h8000_0001, "mtvec_rd");
    csr(2'b10, 12'h304, 64'h800);
    rd(12'h304, 64'h880, "mie_rs");
    bus.I_meip = 1'b1;
    tick();
    check_eq("trap_vec_meip", 64'(bus.O_trap_vec), 64'h8000_002C);
    bus.I_exc = 1'b1;
    #1;
    check_eq("trap_vec_exc", 64'(bus.O_trap_vec), 64'h8000_0000);
    bus.I_exc  = 1'b0;
    bus.I_meip = 1'b0;
    csr(2'b01, 12'h305, 64'h8000_0003);
    rd(12'h305, 64'h8000_0001, "mtvec_bit1_ro");

    // exception beats a same-cycle CSR write; mret restores MIE
    csr(2'b10, 12'h300, 64'h8);
    rd(12'h300, 64'h1888, "mstatus_pre_exc");
    bus.I_exc       = 1'b1;
    bus.I_exc_cause = 64'h2;
    bus.I_trap_pc   = 32'h2000_0010;
    csr(2'b01, 12'h340, 64'hAA);
    bus.I_exc = 1'b0;
    rd(12'h342, 64'h2, "mcause_exc");
    rd(12'h340, 64'h0, "mscratch_dropped");
    rd(12'h300, 64'h1880, "mstatus_exc");
    check_eq("mepc_exc", 64'(bus.O_mepc), 64'h2000_0010);
    bus.I_mret = 1'b1;
    tick();
    bus.I_mret = 1'b0;
    rd(12'h300, 64'h1888, "mstatus_mret");

    // counters: write wins over increment, wrap
    csr(2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
    rd(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, "mcycle_written");
    tick();
    rd(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, "mcycle_max");
    tick();
    rd(12'hB00, 64'h0, "mcycle_wrap");
    csr(2'b01, 12'hB02, 64'h5);
    rd(12'hB02, 64'h5, "minstret_written");
    csr(2'b11, 12'h342, 64'h0);
    rd(12'h342, 64'h2, "mcause_rc_zero");
    rd(12'hB02, 64'h6, "minstret_commit");

    // field masks
    csr(2'b01, 12'h341, 64'h1003);
    rd(12'h341, 64'h1000, "mepc_align");
    csr(2'b11, 12'h304, 64'h80);
    rd(12'h304, 64'h800, "mie_rc");
    csr(2'b10, 12'h344, 64'h8);
    rd(12'h344, 64'h8, "mip_msip_sw");
    csr(2'b11, 12'h344, 64'h8);

    // illegal address
    bus.I_commit    = 1'b1;
    bus.I_csr_op    = 2'b01;
    bus.I_csr_addr  = 12'h7C0;
    bus.I_csr_wdata = 64'hFF;
    #1;
    check_eq("illegal_flag", 64'(bus.O_csr_illegal), 64'h1);
    check_eq("illegal_rdata", bus.O_csr_rdata, 64'h0);
    bus.I_csr_addr = 12'h340;
    #1;
    check_eq("legal_flag", 64'(bus.O_csr_illegal), 64'h0);
    bus.I_csr_addr = 12'h7C0;
    tick();
    bus.I_commit = 1'b0;
    bus.I_csr_op = 2'b00;
    #1;
    check_eq("no_op_not_illegal", 64'(bus.O_csr_illegal), 64'h0);
    rd(12'h340, 64'h0, "mscratch_after_illegal");

    // interrupt cause priority
    csr(2'b01, 12'h304, 64'h888);
    bus.I_msip_ext = 1'b1;
    bus.I_mtip     = 1'b1;
    tick();
    bus.I_irq_ack = 1'b1;
    tick();
    bus.I_irq_ack = 1'b0;
    rd(12'h342, 64'h8000_0000_0000_0003, "cause_msip_over_mtip");
    bus.I_meip = 1'b1;
    tick();
    bus.I_irq_ack = 1'b1;
    tick();
    bus.I_irq_ack = 1'b0;
    rd(12'h342, 64'h8000_0000_0000_000B, "cause_meip_first");

    // reset in the middle of a trap
    bus.I_exc       = 1'b1;
    bus.I_exc_cause = 64'h5;
    bus.I_trap_pc   = 32'h3000_0000;
    rst_n           = 1'b0;
    tick();
    bus.I_exc      = 1'b0;
    bus.I_msip_ext = 1'b0;
    bus.I_mtip     = 1'b0;
    bus.I_meip     = 1'b0;
    rd(12'h300, 64'h1800, "rst2_mstatus");
    rd(12'h342, 64'h0, "rst2_mcause");
    rd(12'h304, 64'h0, "rst2_mie");
    check_eq("rst2_mepc", 64'(bus.O_mepc), 64'h0);
    check_eq("rst2_irq_req", 64'(bus.O_irq_req), 64'h0);
    rst_n = 1'b1;
    rd(12'hB00, 64'h0, "rst2_mcycle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
